// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared peripheral select codes and input-peripheral register offsets
package io_pkg;

    typedef logic [2:0] io_code_t;

    localparam io_code_t CODE_INPUT = 3'b111;
    localparam io_code_t CODE_HEX   = 3'b100;
    localparam io_code_t CODE_LEDG  = 3'b101;
    localparam io_code_t CODE_LEDR  = 3'b110;
    localparam io_code_t CODE_LCD   = 3'b011;

    typedef logic [1:0] in_addr_t;

    localparam in_addr_t IN_SW   = 2'd0;
    localparam in_addr_t IN_KEY  = 2'd1;
    localparam in_addr_t IN_EDGE = 2'd2;
    localparam in_addr_t IN_MASK = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one active-low key: two-flop sync, hold counter, stable level and press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic stable,
    output logic fall_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // Any sample matching the accepted level restarts the hold window.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sync stages reset to released so a key held through reset must re-qualify.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable     = stable_q;
    assign fall_pulse = stable_q & ~stable_d;

endmodule

// File: rtl/input_periph.sv
// rtl/input_periph.sv - load-side input peripheral: switches, debounced keys, sticky press capture, irq mask
module input_periph
    import io_pkg::*;
#(
    parameter int       SW_W            = 18,
    parameter int       KEY_W           = 4,
    parameter int       DEBOUNCE_CYCLES = 16,
    parameter io_code_t SEL_CODE        = CODE_INPUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   i_sw,
    input  logic [KEY_W-1:0]  i_key,
    input  logic [5:0]        addr,
    input  logic [2:0]        code,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [31:0]       st_data,
    output logic [31:0]       ld_data,
    output logic              o_key_irq
);

    logic [SW_W-1:0]  sw_sync1_q, sw_sync1_d;
    logic [SW_W-1:0]  sw_reg_q, sw_reg_d;
    logic [KEY_W-1:0] edge_cap_q, edge_cap_d;
    logic [KEY_W-1:0] irq_mask_q, irq_mask_d;
    logic             key_irq_q, key_irq_d;

    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_fall;
    logic             sel;
    logic             st_hit;
    logic             unused_bits;

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk       (clk),
            .rst       (rst),
            .key_raw   (i_key[g]),
            .stable    (key_stable[g]),
            .fall_pulse(key_fall[g])
        );
    end

    assign sel         = (code == SEL_CODE);
    assign st_hit      = st_en && sel;
    assign unused_bits = ^{addr[5:2], st_data[31:KEY_W]};

    always_comb begin
        sw_sync1_d = i_sw;
        sw_reg_d   = sw_sync1_q;
        edge_cap_d = edge_cap_q;
        irq_mask_d = irq_mask_q;
        if (st_hit) begin
            case (addr[1:0])
                IN_EDGE: edge_cap_d = edge_cap_q & ~st_data[KEY_W-1:0];
                IN_MASK: irq_mask_d = st_data[KEY_W-1:0];
                default: ;
            endcase
        end
        // Press capture is applied after the clear so a same-cycle press survives.
        edge_cap_d = edge_cap_d | key_fall;
        key_irq_d  = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync1_q <= '0;
            sw_reg_q   <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            key_irq_q  <= 1'b0;
        end else begin
            sw_sync1_q <= sw_sync1_d;
            sw_reg_q   <= sw_reg_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            key_irq_q  <= key_irq_d;
        end
    end

    always_comb begin
        ld_data = '0;
        if (ld_en && sel) begin
            case (addr[1:0])
                IN_SW:   ld_data[SW_W-1:0]  = sw_reg_q;
                IN_KEY:  ld_data[KEY_W-1:0] = ~key_stable;
                IN_EDGE: ld_data[KEY_W-1:0] = edge_cap_q;
                IN_MASK: ld_data[KEY_W-1:0] = irq_mask_q;
                default: ;
            endcase
        end
    end

    assign o_key_irq = key_irq_q;

endmodule

// File: tb/tb_input_periph.sv
// tb/tb_input_periph.sv - self-checking bench for input_periph with a behavioural window model
module tb_input_periph;

    localparam int DEB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] i_sw;
    logic [3:0]  i_key;
    logic [5:0]  addr;
    logic [2:0]  code;
    logic        ld_en;
    logic        st_en;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        o_key_irq;

    int checks = 0;
    int errors = 0;

    input_periph #(
        .SW_W(18), .KEY_W(4), .DEBOUNCE_CYCLES(DEB), .SEL_CODE(3'b111)
    ) dut (
        .clk(clk), .rst(rst), .i_sw(i_sw), .i_key(i_key), .addr(addr), .code(code),
        .ld_en(ld_en), .st_en(st_en), .st_data(st_data), .ld_data(ld_data), .o_key_irq(o_key_irq)
    );

    always #5 clk = ~clk;

    // Reference: a key level is accepted once the last DEB synchronized samples all show the new level.
    logic [17:0]    m_sw, m_sw_d1;
    logic [3:0]     m_k1, m_k2, m_stable, m_edge, m_mask;
    logic           m_irq;
    logic [DEB-1:0] m_win [4];

    task automatic model_step();
        logic [3:0] s;
        logic [3:0] press;
        if (rst) begin
            m_sw = '0; m_sw_d1 = '0; m_k1 = '1; m_k2 = '1; m_stable = '1;
            m_edge = '0; m_mask = '0; m_irq = 1'b0;
            for (int k = 0; k < 4; k++) m_win[k] = '1;
        end else begin
            s = m_k2;
            press = '0;
            m_irq = |(m_edge & m_mask);
            for (int k = 0; k < 4; k++) begin
                m_win[k] = {m_win[k][DEB-2:0], s[k]};
                if (m_stable[k] ? (m_win[k] == '0) : (m_win[k] == '1)) begin
                    press[k] = m_stable[k];
                    m_stable[k] = ~m_stable[k];
                end
            end
            if (st_en && code == 3'b111) begin
                if (addr[1:0] == 2'd2) m_edge = m_edge & ~st_data[3:0];
                else if (addr[1:0] == 2'd3) m_mask = st_data[3:0];
            end
            m_edge = m_edge | press;
            m_sw = m_sw_d1; m_sw_d1 = i_sw; m_k2 = m_k1; m_k1 = i_key;
        end
    endtask

    function automatic logic [31:0] exp_ld();
        logic [31:0] r;
        r = '0;
        if (ld_en && code == 3'b111) begin
            case (addr[1:0])
                2'd0: r = {14'b0, m_sw};
                2'd1: r = {28'b0, ~m_stable};
                2'd2: r = {28'b0, m_edge};
                default: r = {28'b0, m_mask};
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_store(input logic [5:0] a, input logic [31:0] d);
        addr = a; code = 3'b111; st_data = d; st_en = 1'b1;
        tick();
        st_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_sw = 18'h3FFFF; i_key = 4'hF; ld_en = 1'b1; code = 3'b111;
        st_en = 1'b0; st_data = '0; addr = '0;
        repeat (3) tick();
        for (int a = 0; a < 4; a++) begin
            addr = 6'(a); #1;
            checks++;
            if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_reg a=%0d got %h exp 0", a, ld_data); end
        end
        checks++;
        if (o_key_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", o_key_irq); end
        rst = 1'b0; addr = 6'd0;
        tick();
        checks++;
        if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_sw_c1 got %h exp 0", ld_data); end
        tick();
        checks++;
        if (ld_data !== 32'h3FFFF) begin errors++; $display("FAIL reset_sw_c2 got %h exp 3ffff", ld_data); end
        for (int a = 1; a < 4; a++) begin
            addr = 6'(a); #1;
            checks++;
            if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_post a=%0d got %h exp 0", a, ld_data); end
        end
    endtask

    task automatic test_switch();
        logic [17:0] v, prev;
        prev = 18'h3FFFF;
        for (int n = 0; n < 6; n++) begin
            v = (n == 0) ? 18'h2A5A5 : 18'($urandom);
            i_sw = v; addr = 6'd0; code = 3'b111; ld_en = 1'b1;
            tick();
            checks++;
            if (ld_data !== {14'b0, prev}) begin errors++; $display("FAIL sw_t1 got %h exp %h", ld_data, {14'b0, prev}); end
            tick();
            checks++;
            if (ld_data !== {14'b0, v} || ld_data !== exp_ld()) begin errors++; $display("FAIL sw_t2 got %h exp %h", ld_data, {14'b0, v}); end
            code = 3'($urandom_range(0, 6)); #1;
            checks++;
            if (ld_data !== 32'h0) begin errors++; $display("FAIL sw_code code=%0d got %h exp 0", code, ld_data); end
            code = 3'b111; ld_en = 1'b0; #1;
            checks++;
            if (ld_data !== 32'h0) begin errors++; $display("FAIL sw_noload got %h exp 0", ld_data); end
            ld_en = 1'b1;
            prev = v;
        end
    endtask

    task automatic test_debounce();
        i_key[0] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick(); addr = 6'd1; #1;
            checks++;
            if (ld_data !== 32'h0) begin errors++; $display("FAIL glitch_key j=%0d got %h exp 0", j, ld_data); end
        end
        i_key[0] = 1'b1;
        repeat (20) tick();
        addr = 6'd2; #1;
        checks++;
        if (ld_data !== 32'h0) begin errors++; $display("FAIL glitch_edge got %h exp 0", ld_data); end
        i_key[0] = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            addr = 6'd1; #1;
            checks++;
            if (ld_data !== ((j >= 18) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL hold_key j=%0d got %h exp %h", j, ld_data, (j >= 18) ? 1 : 0); end
            addr = 6'd2; #1;
            checks++;
            if (ld_data !== ((j >= 18) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL hold_edge j=%0d got %h exp %h", j, ld_data, (j >= 18) ? 1 : 0); end
        end
        i_key[0] = 1'b1;
        for (int j = 1; j <= 25; j++) begin
            tick();
            addr = 6'd1; #1;
            checks++;
            if (ld_data !== ((j >= 18) ? 32'h0 : 32'h1)) begin errors++; $display("FAIL rel_key j=%0d got %h", j, ld_data); end
            addr = 6'd2; #1;
            checks++;
            if (ld_data !== 32'h1) begin errors++; $display("FAIL rel_edge j=%0d got %h exp 1", j, ld_data); end
        end
    endtask

    task automatic test_w1c_race();
        do_store(6'd2, 32'hF);
        i_key[1:0] = 2'b00;
        repeat (20) tick();
        i_key = 4'hF;
        repeat (20) tick();
        addr = 6'd2; ld_en = 1'b1; #1;
        checks++;
        if (ld_data !== 32'h3) begin errors++; $display("FAIL edge_pair got %h exp 3", ld_data); end
        st_en = 1'b1; st_data = 32'h1; #1;
        checks++;
        if (ld_data !== 32'h3) begin errors++; $display("FAIL ld_during_st got %h exp 3", ld_data); end
        tick();
        st_en = 1'b0; #1;
        checks++;
        if (ld_data !== 32'h2) begin errors++; $display("FAIL w1c_bit0 got %h exp 2", ld_data); end
        do_store(6'd2, 32'h2);
        i_key[1] = 1'b0;
        repeat (17) tick();
        addr = 6'd2; #1;
        checks++;
        if (ld_data !== 32'h0) begin errors++; $display("FAIL race_pre got %h exp 0", ld_data); end
        st_en = 1'b1; st_data = 32'h2;
        tick();
        st_en = 1'b0; #1;
        checks++;
        if (ld_data !== 32'h2 || ld_data !== exp_ld()) begin errors++; $display("FAIL race_set_wins got %h exp 2", ld_data); end
        i_key[1] = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_irq();
        do_store(6'd2, 32'hF);
        do_store(6'd3, 32'h4);
        addr = 6'd3; #1;
        checks++;
        if (ld_data !== 32'h4) begin errors++; $display("FAIL mask_rd got %h exp 4", ld_data); end
        i_key[2] = 1'b0;
        for (int j = 1; j <= 19; j++) begin
            tick();
            if (j == 18) begin
                checks++;
                if (o_key_irq !== 1'b0) begin errors++; $display("FAIL irq_capture_cycle got %b exp 0", o_key_irq); end
            end
            if (j == 19) begin
                checks++;
                if (o_key_irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", o_key_irq); end
            end
        end
        i_key[2] = 1'b1;
        repeat (20) tick();
        do_store(6'd2, 32'h4);
        tick();
        checks++;
        if (o_key_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", o_key_irq); end
        i_key[0] = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            tick();
            checks++;
            if (o_key_irq !== 1'b0) begin errors++; $display("FAIL irq_masked j=%0d got %b exp 0", j, o_key_irq); end
        end
        i_key[0] = 1'b1;
        repeat (20) tick();
        addr = 6'd2; #1;
        checks++;
        if (ld_data !== 32'h1) begin errors++; $display("FAIL masked_edge got %h exp 1", ld_data); end
    endtask

    task automatic test_reset_mid();
        i_key[3] = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            tick();
            addr = 6'd1; #1;
            checks++;
            if (ld_data !== ((j >= 18) ? 32'h8 : 32'h0)) begin errors++; $display("FAIL rmid_key j=%0d got %h", j, ld_data); end
            addr = 6'd2; #1;
            checks++;
            if (ld_data !== ((j >= 18) ? 32'h8 : 32'h0)) begin errors++; $display("FAIL rmid_edge j=%0d got %h", j, ld_data); end
        end
        do_store(6'd2, 32'h8);
        repeat (20) tick();
        addr = 6'd2; #1;
        checks++;
        if (ld_data !== 32'h0) begin errors++; $display("FAIL rmid_once got %h exp 0", ld_data); end
        i_key[3] = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_random();
        int idx;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, 3);
                i_key[idx] = ~i_key[idx];
            end
            if ($urandom_range(0, 7) == 0) i_sw = 18'($urandom);
            st_en   = ($urandom_range(0, 9) == 0);
            st_data = $urandom;
            addr    = 6'($urandom);
            code    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            ld_en   = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 599) == 0);
            #1;
            checks++;
            if (ld_data !== exp_ld()) begin errors++; $display("FAIL rand_ld n=%0d got %h exp %h", n, ld_data, exp_ld()); end
            checks++;
            if (o_key_irq !== m_irq) begin errors++; $display("FAIL rand_irq n=%0d got %b exp %b", n, o_key_irq, m_irq); end
            tick();
        end
        rst = 1'b0; st_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_debounce();
        test_w1c_race();
        test_irq();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
